// File: rtl/datamem_dump_pkg.sv
// ----------------------------------------------------------------------------
// datamem_dump_pkg
// Shared definitions for the data-memory dump sequencer:
//   - NB_DUMP_ADDR   : width of the debug-port word address and word count
//   - NB_REG_DEFAULT : default data word width
//   - N_ADDR_DEFAULT : default data-memory depth in words (address wrap point)
//   - dump_state_e   : 3-bit FSM state encoding
// ----------------------------------------------------------------------------
package datamem_dump_pkg;

    localparam int NB_DUMP_ADDR   = 16;
    localparam int NB_REG_DEFAULT = 32;
    localparam int N_ADDR_DEFAULT = 2048;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_SEND     = 3'd3,
        ST_CHECKSUM = 3'd4,
        ST_DONE     = 3'd5
    } dump_state_e;

endpackage

// File: rtl/datamem_dump_ctrl_if.sv
// ----------------------------------------------------------------------------
// datamem_dump_ctrl_if
// Bundles the command, debug memory port, output stream and status signals of
// the dump sequencer.
//   slave  : sequencer view (inputs i_*, outputs o_*)
//   master : environment view (debug unit, memory, transmitter)
// Signals:
//   i_start/i_base_addr/i_count : dump command
//   o_mem_addr/o_mem_re/i_mem_data : data-memory debug read port
//   o_data/o_valid/i_ready : valid/ready word stream towards the UART framer
//   o_busy/o_done : status
// ----------------------------------------------------------------------------
interface datamem_dump_ctrl_if
    import datamem_dump_pkg::*;
#(
    parameter int NB_REG  = NB_REG_DEFAULT,
    parameter int NB_ADDR = NB_DUMP_ADDR
);
    logic               i_start;
    logic [NB_ADDR-1:0] i_base_addr;
    logic [NB_ADDR-1:0] i_count;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic               o_mem_re;
    logic [NB_REG-1:0]  i_mem_data;
    logic [NB_REG-1:0]  o_data;
    logic               o_valid;
    logic               i_ready;
    logic               o_busy;
    logic               o_done;

    modport slave (
        input  i_start, i_base_addr, i_count, i_mem_data, i_ready,
        output o_mem_addr, o_mem_re, o_data, o_valid, o_busy, o_done
    );

    modport master (
        output i_start, i_base_addr, i_count, i_mem_data, i_ready,
        input  o_mem_addr, o_mem_re, o_data, o_valid, o_busy, o_done
    );

endinterface

// File: rtl/dump_addr_counter.sv
// ----------------------------------------------------------------------------
// dump_addr_counter
// Loadable word-address counter with modulo-N_ADDR wrap, plus a down-counter of
// words still to dump.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : latch base_i (reduced modulo N_ADDR) and count_i
//   base_i       : first word address
//   count_i      : number of words
//   step_i       : one word done: address +1 (wrapping), remaining -1
//   addr_o       : current word address (registered)
//   last_o       : remaining == 1, i.e. the next step empties the counter
//   zero_o       : remaining == 0
// ----------------------------------------------------------------------------
module dump_addr_counter #(
    parameter int NB_ADDR = 16,
    parameter int N_ADDR  = 2048
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [NB_ADDR-1:0] base_i,
    input  logic [NB_ADDR-1:0] count_i,
    input  logic               step_i,
    output logic [NB_ADDR-1:0] addr_o,
    output logic               last_o,
    output logic               zero_o
);

    localparam logic [NB_ADDR-1:0] N_MOD    = NB_ADDR'(N_ADDR);
    localparam logic [NB_ADDR-1:0] ADDR_MAX = NB_ADDR'(N_ADDR - 1);

    logic [NB_ADDR-1:0] addr_q;
    logic [NB_ADDR-1:0] addr_d;
    logic [NB_ADDR-1:0] rem_q;
    logic [NB_ADDR-1:0] rem_d;

    // A depth covering the whole address space needs no reduction (and N_MOD
    // would truncate to zero).
    function automatic logic [NB_ADDR-1:0] wrap_base(input logic [NB_ADDR-1:0] a);
        logic [NB_ADDR-1:0] r;
        if (N_ADDR >= (1 << NB_ADDR)) begin
            r = a;
        end else begin
            r = a % N_MOD;
        end
        return r;
    endfunction

    function automatic logic [NB_ADDR-1:0] next_addr(input logic [NB_ADDR-1:0] a);
        logic [NB_ADDR-1:0] r;
        if (a == ADDR_MAX) begin
            r = {NB_ADDR{1'b0}};
        end else begin
            r = a + NB_ADDR'(1);
        end
        return r;
    endfunction

    // Next-state for address and remaining count.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = wrap_base(base_i);
            rem_d  = count_i;
        end else if (step_i) begin
            addr_d = next_addr(addr_q);
            rem_d  = rem_q - NB_ADDR'(1);
        end else begin
            addr_d = addr_q;
            rem_d  = rem_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= {NB_ADDR{1'b0}};
            rem_q  <= {NB_ADDR{1'b0}};
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (rem_q == NB_ADDR'(1));
    assign zero_o = (rem_q == {NB_ADDR{1'b0}});

endmodule

// File: rtl/datamem_dump_ctrl.sv
// ----------------------------------------------------------------------------
// datamem_dump_ctrl
// Sequencer for the debug read port of the data memory. On a start command it
// reads i_count words from i_base_addr (wrapping at N_ADDR), one word per
// ISSUE/CAPTURE/SEND round, and presents each on a valid/ready stream.
// Ports:
//   i_clock : system clock
//   i_reset : synchronous, active-high reset (aborts a dump immediately)
//   bus     : datamem_dump_ctrl_if.slave (command, memory port, stream, status)
// Build option:
//   DATAMEM_DUMP_CHECKSUM_EN - append one beat carrying the modulo-2^NB_REG
//   sum of all dumped words; a zero-length dump then yields a single 0 beat.
// ----------------------------------------------------------------------------
module datamem_dump_ctrl
    import datamem_dump_pkg::*;
#(
    parameter int NB_REG  = NB_REG_DEFAULT,
    parameter int NB_ADDR = NB_DUMP_ADDR,
    parameter int N_ADDR  = N_ADDR_DEFAULT
) (
    input  logic          i_clock,
    input  logic          i_reset,
    datamem_dump_ctrl_if.slave bus
);

    dump_state_e        state_q;
    dump_state_e        state_d;
    logic [NB_REG-1:0]  data_q;
    logic [NB_REG-1:0]  data_d;
    logic               valid_q;
    logic               valid_d;
    logic               mem_re_q;
    logic               mem_re_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
    logic [NB_REG-1:0]  acc_q;
    logic [NB_REG-1:0]  acc_d;
`endif

    logic               cnt_load_s;
    logic               cnt_step_s;
    logic [NB_ADDR-1:0] cnt_addr_s;
    logic               cnt_last_s;
    logic               cnt_zero_s;
    logic               handshake_s;

    assign handshake_s = valid_q & bus.i_ready;

    dump_addr_counter #(
        .NB_ADDR (NB_ADDR),
        .N_ADDR  (N_ADDR)
    ) u_addr_counter (
        .clk_i   (i_clock),
        .rst_i   (i_reset),
        .load_i  (cnt_load_s),
        .base_i  (bus.i_base_addr),
        .count_i (bus.i_count),
        .step_i  (cnt_step_s),
        .addr_o  (cnt_addr_s),
        .last_o  (cnt_last_s),
        .zero_o  (cnt_zero_s)
    );

    // FSM next-state and next values of all registered outputs.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q;
        mem_re_d   = 1'b0;
        done_d     = 1'b0;
        cnt_load_s = 1'b0;
        cnt_step_s = 1'b0;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
        acc_d      = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    cnt_load_s = 1'b1;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
                    acc_d      = {NB_REG{1'b0}};
`endif
                    if (bus.i_count != {NB_ADDR{1'b0}}) begin
                        state_d  = ST_ISSUE;
                        mem_re_d = 1'b1;
                    end else begin
`ifdef DATAMEM_DUMP_CHECKSUM_EN
                        // Empty dump still carries its (zero) checksum beat.
                        state_d = ST_CHECKSUM;
                        data_d  = {NB_REG{1'b0}};
                        valid_d = 1'b1;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Guard only: ISSUE is never entered with nothing left to read.
                if (cnt_zero_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                data_d  = bus.i_mem_data;
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (handshake_s) begin
                    valid_d    = 1'b0;
                    cnt_step_s = 1'b1;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
                    acc_d      = acc_q + data_q;
`endif
                    if (cnt_last_s) begin
`ifdef DATAMEM_DUMP_CHECKSUM_EN
                        state_d = ST_CHECKSUM;
                        data_d  = acc_q + data_q;
                        valid_d = 1'b1;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d  = ST_ISSUE;
                        mem_re_d = 1'b1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
`ifdef DATAMEM_DUMP_CHECKSUM_EN
            ST_CHECKSUM: begin
                if (handshake_s) begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_CHECKSUM;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            data_q   <= {NB_REG{1'b0}};
            valid_q  <= 1'b0;
            mem_re_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
            acc_q    <= {NB_REG{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            mem_re_q <= mem_re_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef DATAMEM_DUMP_CHECKSUM_EN
            acc_q    <= acc_d;
`endif
        end
    end

    // The address register lives in the counter; it only changes on load or
    // step, so it is stable whenever o_mem_re is high.
    assign bus.o_mem_addr = cnt_addr_s;
    assign bus.o_mem_re   = mem_re_q;
    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;

endmodule
